// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master.
// master modport: the requester side; slave modport: the controller plus
// completer side that surrounds it.
interface apb_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslver;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  pready, pslver, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output pready, pslver, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: turns valid/ready commands into APB transfers and returns
// one response (read data + error) per command.
// Optional macro APB_MASTER_TIMEOUT_EN bounds the ACCESS wait to TIMEOUT cycles.
//
// state  | meaning
// IDLE   | bus idle, ready for a command
// SETUP  | psel=1, penable=0, address/data phase start
// ACCESS | psel=1, penable=1, waiting for pready
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic          pclk,
  input logic          prst,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   complete;
  logic   expire;

  // Ready in IDLE, or in ACCESS when the current transfer finishes this cycle.
  assign bus.cmd_ready = !prst && ((state == IDLE) || ((state == ACCESS) && bus.pready));
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign complete      = (state == ACCESS) && bus.pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Expire on the ACCESS cycle that would bring the count up to TIMEOUT.
  assign expire = (state == ACCESS) && !bus.pready && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Wait-state counter: zero outside ACCESS, counts cycles without pready.
  always_ff @(posedge pclk) begin
    if (prst) begin
      tmo_cnt <= '0;
    end else if (state != ACCESS) begin
      tmo_cnt <= '0;
    end else if (!bus.pready) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // State register.
  always_ff @(posedge pclk) begin
    if (prst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a command accepted on completion goes straight to SETUP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (complete)    state_nxt = accept ? SETUP : IDLE;
        else if (expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered APB outputs, command capture and response generation.
  always_ff @(posedge pclk) begin
    if (prst) begin
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pwdata    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.psel      <= (state_nxt != IDLE);
      bus.penable   <= (state_nxt == ACCESS);
      bus.rsp_valid <= complete || expire;
      if (accept) begin
        bus.paddr  <= bus.cmd_addr;
        bus.pwdata <= bus.cmd_wdata;
        bus.pwrite <= bus.cmd_write;
      end
      if (complete) begin
        bus.rsp_err   <= bus.pslver;
        bus.rsp_rdata <= bus.pwrite ? '0 : bus.prdata;
      end else if (expire) begin
        bus.rsp_err   <= 1'b1;
        bus.rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a vector table of single transfers plus
// hand-written back-to-back, reset-abort and (with APB_MASTER_TIMEOUT_EN)
// timeout sequences.
module tb_apb_master;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 16;
`endif

  logic pclk;
  logic prst;
  int   n_cmp = 0;
  int   n_err = 0;

  apb_master_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus.master)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        pslver;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Issues one command from IDLE and plays the completer; ends on a negedge.
  task automatic run_vec(input vec_t v);
    @(negedge pclk);
    check("ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.write;
    bus.cmd_addr  = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.pslver    = v.pslver;
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = ~v.addr;
    bus.cmd_wdata = ~v.wdata;
    bus.cmd_write = ~v.write;
    @(negedge pclk);
    check("setup_psel", bus.psel, 1);
    check("setup_penable", bus.penable, 0);
    check("setup_ready", bus.cmd_ready, 0);
    check("setup_paddr", bus.paddr, v.addr);
    check("setup_pwrite", bus.pwrite, v.write);
    check("setup_pwdata", bus.pwdata, v.wdata);
    for (int k = 0; k <= v.waits; k++) begin
      @(negedge pclk);
      check("access_psel", bus.psel, 1);
      check("access_penable", bus.penable, 1);
      check("access_paddr", bus.paddr, v.addr);
      check("access_pwdata", bus.pwdata, v.wdata);
      check("access_no_rsp", bus.rsp_valid, 0);
      bus.pready = (k == v.waits);
      bus.prdata = v.prdata;
      @(posedge pclk);
      #1;
      bus.pready = 1'b0;
      bus.prdata = 32'h0BAD_0BAD;
    end
    bus.pslver = 1'b0;
    @(negedge pclk);
    check("rsp_valid", bus.rsp_valid, 1);
    check("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("rsp_err", bus.rsp_err, v.exp_err);
    check("done_psel", bus.psel, 0);
    check("done_penable", bus.penable, 0);
    @(negedge pclk);
    check("rsp_pulse_end", bus.rsp_valid, 0);
    check("rsp_rdata_hold", bus.rsp_rdata, v.exp_rdata);
    check("rsp_err_hold", bus.rsp_err, v.exp_err);
  endtask

  initial begin
    //        write addr   wdata         waits prdata        err  exp_rdata     exp_err
    vecs[0] = '{1'b1, 8'h05, 32'hDEADBEEF, 0, 32'h1234_5678, 1'b0, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 8'h05, 32'h0,        3, 32'hDEADBEEF,  1'b0, 32'hDEADBEEF,  1'b0};
    vecs[2] = '{1'b0, 8'h33, 32'h0,        0, 32'hCAFEF00D,  1'b1, 32'hCAFEF00D,  1'b1};
    vecs[3] = '{1'b1, 8'hA0, 32'h0000_1111, 1, 32'h5555_AAAA, 1'b0, 32'h0,        1'b0};
    vecs[4] = '{1'b1, 8'h7E, 32'h8000_0001, 2, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b1};
    vecs[5] = '{1'b0, 8'hFF, 32'h0,        0, 32'h0000_0000, 1'b0, 32'h0,         1'b0};

    prst          = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h3C;
    bus.cmd_wdata = 32'h1357_9BDF;
    bus.pready    = 1'b1;
    bus.pslver    = 1'b1;
    bus.prdata    = 32'hFFFF_FFFF;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_pwrite", bus.pwrite, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    bus.pslver    = 1'b0;
    prst          = 1'b0;
    #1;
    check("rst_release_ready", bus.cmd_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Back-to-back: write 0x01/0x11 then read 0x02 with cmd_valid held.
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h01;
    bus.cmd_wdata = 32'h11;
    @(posedge pclk);
    #1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h02;
    bus.cmd_wdata = 32'h0;
    @(negedge pclk);
    check("b2b_setup1_ready", bus.cmd_ready, 0);
    check("b2b_setup1_psel", bus.psel, 1);
    check("b2b_setup1_penable", bus.penable, 0);
    check("b2b_setup1_paddr", bus.paddr, 8'h01);
    check("b2b_setup1_pwdata", bus.pwdata, 32'h11);
    @(negedge pclk);
    check("b2b_access1_psel", bus.psel, 1);
    check("b2b_access1_penable", bus.penable, 1);
    check("b2b_access1_paddr", bus.paddr, 8'h01);
    bus.pready = 1'b1;
    bus.prdata = 32'hFFFF_0000;
    #1;
    check("b2b_access1_ready", bus.cmd_ready, 1);
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.pready    = 1'b0;
    // First response lands in the second SETUP cycle.
    @(negedge pclk);
    check("b2b_rsp1_valid", bus.rsp_valid, 1);
    check("b2b_rsp1_rdata", bus.rsp_rdata, 0);
    check("b2b_rsp1_err", bus.rsp_err, 0);
    check("b2b_setup2_psel", bus.psel, 1);
    check("b2b_setup2_penable", bus.penable, 0);
    check("b2b_setup2_paddr", bus.paddr, 8'h02);
    check("b2b_setup2_pwrite", bus.pwrite, 0);
    @(negedge pclk);
    check("b2b_access2_psel", bus.psel, 1);
    check("b2b_access2_penable", bus.penable, 1);
    check("b2b_access2_no_rsp", bus.rsp_valid, 0);
    bus.pready = 1'b1;
    bus.prdata = 32'h0000_0202;
    @(posedge pclk);
    #1;
    bus.pready = 1'b0;
    @(negedge pclk);
    check("b2b_rsp2_valid", bus.rsp_valid, 1);
    check("b2b_rsp2_rdata", bus.rsp_rdata, 32'h0000_0202);
    check("b2b_rsp2_err", bus.rsp_err, 0);
    check("b2b_idle_psel", bus.psel, 0);

    // Reset during an ACCESS wait state aborts without a response.
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h44;
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    check("abort_access_penable", bus.penable, 1);
    @(negedge pclk);
    prst       = 1'b1;
    bus.pready = 1'b0;
    #1;
    check("abort_ready_low", bus.cmd_ready, 0);
    @(posedge pclk);
    #1;
    check("abort_psel", bus.psel, 0);
    check("abort_penable", bus.penable, 0);
    check("abort_no_rsp", bus.rsp_valid, 0);
    check("abort_ready_rst", bus.cmd_ready, 0);
    @(negedge pclk);
    prst       = 1'b0;
    bus.pready = 1'b1;
    @(negedge pclk);
    check("abort_no_rsp_after", bus.rsp_valid, 0);
    bus.pready = 1'b0;
    run_vec('{1'b0, 8'h44, 32'h0, 1, 32'h5A5A_5A5A, 1'b0, 32'h5A5A_5A5A, 1'b0});

`ifdef APB_MASTER_TIMEOUT_EN
    // pready held low: transfer terminated after TMO ACCESS cycles.
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h77;
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    check("tmo_setup_psel", bus.psel, 1);
    for (int k = 0; k < TMO; k++) begin
      @(negedge pclk);
      check("tmo_access_penable", bus.penable, 1);
      check("tmo_access_no_rsp", bus.rsp_valid, 0);
    end
    @(negedge pclk);
    check("tmo_psel", bus.psel, 0);
    check("tmo_penable", bus.penable, 0);
    check("tmo_rsp_valid", bus.rsp_valid, 1);
    check("tmo_rsp_err", bus.rsp_err, 1);
    check("tmo_rsp_rdata", bus.rsp_rdata, 0);
    bus.pready = 1'b1;
    bus.prdata = 32'h1234_0000;
    @(negedge pclk);
    check("tmo_late_ready_ignored", bus.rsp_valid, 0);
    check("tmo_err_hold", bus.rsp_err, 1);
    bus.pready = 1'b0;
`endif

    @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
